// File: rtl/ins_loader.sv
// Byte-stream instruction loader: packs little-endian bytes into 32-bit words and writes them to instruction memory.
// Optional running word checksum is enabled by defining INS_LOADER_CHECKSUM_EN.
module ins_loader #(
   parameter int unsigned DEPTH = 128,
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   input  logic          byte_last,
   output logic          byte_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [31:0]   wr_data,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] word_count,
   output logic [31:0]   checksum
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_DONE
   } state_t;

   state_t     state;
   logic [1:0] byte_idx;
   logic       last_word;

   // wr_data doubles as the assembly buffer; it is cleared before each new word so short words pad with zeros
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         byte_ready <= 1'b0;
         wr_en      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         word_count <= '0;
         byte_idx   <= '0;
         last_word  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_RECV;
                  byte_ready <= 1'b1;
                  busy       <= 1'b1;
                  word_count <= '0;
                  byte_idx   <= '0;
                  wr_data    <= '0;
                  last_word  <= 1'b0;
               end
            end
            S_RECV: begin
               if (byte_valid && byte_ready) begin
                  wr_data[{byte_idx, 3'b000} +: 8] <= byte_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3 || byte_last) begin
                     state      <= S_WRITE;
                     byte_ready <= 1'b0;
                     wr_en      <= 1'b1;
                     wr_addr    <= word_count[AW-1:0];
                     last_word  <= byte_last;
                  end
               end
            end
            S_WRITE: begin
               wr_en      <= 1'b0;
               word_count <= word_count + CW'(1);
               if (last_word || word_count == CW'(DEPTH - 1)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  state      <= S_RECV;
                  byte_ready <= 1'b1;
                  byte_idx   <= '0;
                  wr_data    <= '0;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef INS_LOADER_CHECKSUM_EN
   // Sum of every word written this session, wrapping modulo 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if (state == S_IDLE && start) begin
         checksum <= '0;
      end else if (state == S_WRITE) begin
         checksum <= checksum + wr_data;
      end
   end
`else
   assign checksum = '0;
`endif

endmodule
